// File: rtl/key_pio_slave.sv
// Avalon-MM push-button responder: synchronise, debounce, press capture, interrupt and press count.
// Define KEY_PIO_IRQ_EN to build IRQMASK, EDGECAP and irq; otherwise they read as 0 and irq is tied low.
module key_pio_slave #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    input  logic [WIDTH-1:0] key_n,
    output logic             irq
);

    localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1, sync2, stable, press;
    logic [CW-1:0]    cnt [WIDTH];
    logic [15:0]      presscnt, pop;
    logic [31:0]      mask_rd, edgecap_rd;
    logic             wr_cnt;
    logic             unused_wdata;

    assign wr_cnt       = avs_write && (avs_address == 2'd3);
    assign unused_wdata = ^avs_writedata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            stable <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press is decoded from the pending load so capture lands on the same edge as stable.
    always_comb begin
        press = '0;
        pop   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            press[i] = !stable[i] && sync2[i] && (cnt[i] == CNT_LAST);
            pop      = pop + 16'(press[i]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)
            presscnt <= '0;
        else if (wr_cnt)
            presscnt <= pop;
        else
            presscnt <= presscnt + pop;
    end

`ifdef KEY_PIO_IRQ_EN
    logic [WIDTH-1:0] irq_mask, edgecap;
    logic             wr_mask, wr_edge;

    assign wr_mask = avs_write && (avs_address == 2'd1);
    assign wr_edge = avs_write && (avs_address == 2'd2);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            irq_mask <= '0;
            edgecap  <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mask)
                irq_mask <= avs_writedata[WIDTH-1:0];
            if (wr_edge)
                edgecap <= (edgecap & ~avs_writedata[WIDTH-1:0]) | press;
            else
                edgecap <= edgecap | press;
            irq <= |(edgecap & irq_mask);
        end
    end

    assign mask_rd    = 32'(irq_mask);
    assign edgecap_rd = 32'(edgecap);
`else
    assign mask_rd    = '0;
    assign edgecap_rd = '0;
    assign irq        = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read && !avs_write) begin
            case (avs_address)
                2'd0:    avs_readdata <= 32'(stable);
                2'd1:    avs_readdata <= mask_rd;
                2'd2:    avs_readdata <= edgecap_rd;
                default: avs_readdata <= {16'h0000, presscnt};
            endcase
        end
    end

endmodule

// File: tb/tb_key_pio_slave.sv
// Directed bench for key_pio_slave: debounce timing, glitch rejection, edge capture, irq, press count and wrap.
module tb_key_pio_slave;

`ifdef KEY_PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  address;
    logic        rd_en, wr_en;
    logic [31:0] wdata, rdata;
    logic [3:0]  key_n;
    logic        irq;

    logic [1:0]  w_address;
    logic        w_read;
    logic [31:0] w_rdata;
    logic [31:0] w_key_n;
    logic        w_irq;

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] d;

    always #5 clk = ~clk;

    key_pio_slave #(.WIDTH(4), .DEBOUNCE_CYCLES(16)) dut (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .avs_address  (address),
        .avs_read     (rd_en),
        .avs_write    (wr_en),
        .avs_writedata(wdata),
        .avs_readdata (rdata),
        .key_n        (key_n),
        .irq          (irq)
    );

    // Wide, fast-debounce instance so the 16-bit wrap is reachable in a short run.
    key_pio_slave #(.WIDTH(32), .DEBOUNCE_CYCLES(2)) u_wrap (
        .clk_clk      (clk),
        .reset_reset_n(rst_n),
        .avs_address  (w_address),
        .avs_read     (w_read),
        .avs_write    (1'b0),
        .avs_writedata(32'h0),
        .avs_readdata (w_rdata),
        .key_n        (w_key_n),
        .irq          (w_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] data);
        address = a;
        rd_en   = 1'b1;
        tick();
        rd_en   = 1'b0;
        data    = rdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] data);
        address = a;
        wdata   = data;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        address   = 2'd0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        wdata     = '0;
        key_n     = 4'hF;
        w_address = 2'd3;
        w_read    = 1'b0;
        w_key_n   = '1;

        repeat (3) tick();
        check("rst_readdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        tick();

        bus_rd(2'd0, d); check("rst_data", d, 32'h0);
        bus_rd(2'd1, d); check("rst_mask", d, 32'h0);
        bus_rd(2'd2, d); check("rst_edgecap", d, 32'h0);
        bus_rd(2'd3, d); check("rst_presscnt", d, 32'h0);
        check("rst_irq_after", {31'h0, irq}, 32'h0);

        // Key 0 press: stable loads on the 18th edge, so a read sampled there still sees 0.
        key_n = 4'b1110;
        repeat (17) tick();
        bus_rd(2'd0, d); check("data_edge18", d, 32'h0);
        bus_rd(2'd0, d); check("data_edge19", d, 32'h1);
        bus_rd(2'd2, d); check("edgecap_k0", d, IRQ_EN ? 32'h1 : 32'h0);
        bus_rd(2'd3, d); check("presscnt_k0", d, 32'h1);
        check("irq_masked", {31'h0, irq}, 32'h0);

        // 10-cycle glitch on key 1 must be rejected.
        key_n = 4'b1100;
        repeat (10) tick();
        key_n = 4'b1110;
        repeat (30) tick();
        bus_rd(2'd0, d); check("glitch_data", d, 32'h1);
        bus_rd(2'd2, d); check("glitch_edgecap", d, IRQ_EN ? 32'h1 : 32'h0);
        bus_rd(2'd3, d); check("glitch_presscnt", d, 32'h1);

        bus_wr(2'd0, 32'hF);
        bus_rd(2'd0, d); check("data_ro", d, 32'h1);

        bus_wr(2'd2, 32'h1);
        bus_rd(2'd2, d); check("edgecap_w1c", d, 32'h0);
        bus_wr(2'd1, 32'hFFFF_FFF1);
        bus_rd(2'd1, d); check("mask_upper_zero", d, IRQ_EN ? 32'h1 : 32'h0);
        check("irq_after_mask", {31'h0, irq}, 32'h0);

        key_n = 4'b1111;
        repeat (25) tick();
        bus_rd(2'd2, d); check("release_ignored", d, 32'h0);
        bus_rd(2'd3, d); check("release_nocount", d, 32'h1);

        key_n = 4'b1110;
        repeat (18) tick();
        check("irq_same_edge", {31'h0, irq}, 32'h0);
        tick();
        check("irq_rise", {31'h0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        bus_wr(2'd2, 32'h1);
        check("irq_hold", {31'h0, irq}, IRQ_EN ? 32'h1 : 32'h0);
        tick();
        check("irq_fall", {31'h0, irq}, 32'h0);
        bus_rd(2'd3, d); check("presscnt_2", d, 32'h2);

        // Keys 2 and 3 together; W1C of bit 2 lands on the capture edge.
        key_n = 4'b0010;
        repeat (17) tick();
        bus_wr(2'd2, 32'h4);
        bus_rd(2'd2, d); check("edgecap_set_wins", d, IRQ_EN ? 32'hC : 32'h0);
        bus_rd(2'd3, d); check("presscnt_pop2", d, 32'h4);
        bus_rd(2'd0, d); check("data_k023", d, 32'hD);
        check("irq_unmasked_bits", {31'h0, irq}, 32'h0);

        // Clear-write on the same edge as a press leaves that edge's popcount.
        key_n = 4'b1111;
        repeat (25) tick();
        key_n = 4'b1101;
        repeat (17) tick();
        bus_wr(2'd3, 32'h0);
        bus_rd(2'd3, d); check("clear_vs_press", d, 32'h1);
        bus_wr(2'd3, 32'hDEAD_BEEF);
        bus_rd(2'd3, d); check("presscnt_clear", d, 32'h0);

        for (int i = 0; i < 2047; i++) begin
            w_key_n = '0;
            repeat (6) tick();
            w_key_n = '1;
            repeat (6) tick();
        end
        w_key_n = 32'h8000_0000;
        repeat (6) tick();
        w_key_n = '1;
        repeat (6) tick();
        w_read = 1'b1; tick(); w_read = 1'b0;
        check("wrap_ffff", w_rdata, 32'h0000_FFFF);
        w_key_n = 32'hFFFF_FFFE;
        repeat (6) tick();
        w_read = 1'b1; tick(); w_read = 1'b0;
        check("wrap_zero", w_rdata, 32'h0);
        check("wrap_irq", {31'h0, w_irq}, 32'h0);

        // Reset in the middle of a key-0 debounce.
        key_n = 4'b1111;
        repeat (25) tick();
        key_n = 4'b1110;
        repeat (4) tick();
        bus_rd(2'd1, d); check("mask_before_rst", d, IRQ_EN ? 32'h1 : 32'h0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_readdata", rdata, 32'h0);
        check("async_rst_irq", {31'h0, irq}, 32'h0);
        key_n = 4'b1111;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        bus_rd(2'd0, d); check("post_rst_data", d, 32'h0);
        bus_rd(2'd1, d); check("post_rst_mask", d, 32'h0);
        bus_rd(2'd2, d); check("post_rst_edgecap", d, 32'h0);
        bus_rd(2'd3, d); check("post_rst_presscnt", d, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_pio_slave.md
# key_pio_slave

Avalon-MM responder that the HPS reads through the lightweight HPS-to-FPGA bridge to get push-button state. It sits in the FPGA fabric between the board's active-low KEY pins and the HPS.

- Synchronises and debounces each key.
- Captures press edges and raises a maskable interrupt.
- Counts presses.
- Exposes everything as four word-addressed 32-bit registers.

## Interface
- `WIDTH`, default 4: number of keys, 1..32.
- `DEBOUNCE_CYCLES`, default 50000: cycles a new level must hold before it is accepted. At 50 MHz this is 1 ms. Must be ≥ 2.
- `clk_clk`  in  1  system clock. All logic is on this one clock.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `avs_address`  in  2  word address of the register.
- `avs_read`  in  1  read strobe, one cycle per access.
- `avs_write`  in  1  write strobe, one cycle per access.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered.
- `key_n`  in  WIDTH  raw board keys, active-low, asynchronous to `clk_clk`.
- `irq`  out  1  level interrupt to the HPS, active-high.

## Operation
Input path, per key:
- Invert `key_n` so that 1 means pressed.
- Pass it through a 2-flop synchroniser. Both flops reset to 0, meaning released, so reset cannot produce a spurious press.
- Debounce counter, `$clog2(DEBOUNCE_CYCLES)` bits:
  - If the synchronised value equals the stable value, clear the counter.
  - Otherwise increment it.
  - When the counter reaches `DEBOUNCE_CYCLES-1`, load the stable value from the synchronised value and clear the counter.
- A glitch shorter than `DEBOUNCE_CYCLES` never reaches the stable value.

Event detection:
- A press event for key i is a 0→1 transition of stable[i].
- Release edges are ignored.

Register map (word address):
- 0 DATA (read-only): `{0, stable[WIDTH-1:0]}`. Writes are ignored.
- 1 IRQMASK (read/write): bits [WIDTH-1:0]. Upper bits read 0.
- 2 EDGECAP (read, write-1-to-clear):
  - Bit i sets on a press event of key i.
  - Writing 1 to a bit clears it.
  - If set and clear hit the same bit in the same cycle, set wins.
- 3 PRESSCNT (read/write-clear):
  - 16-bit count of press events, all keys summed. Bits [31:16] read 0.
  - If several keys press in the same cycle, add the number of keys pressing (popcount).
  - The count wraps modulo 2^16.
  - A write with any data clears it to 0. A press in the same cycle as the write clear leaves the counter at that cycle's popcount.

Bus behaviour:
- Reads have no side effects.
- Simultaneous `avs_read` and `avs_write` is illegal. The block performs the write; readdata is don't-care.
- Reset values: `avs_readdata` = 0, `irq` = 0, IRQMASK = 0, EDGECAP = 0, PRESSCNT = 0, stable = 0, counters = 0.
- Reset asserted mid-debounce or mid-access returns every register to its reset value immediately. No pending event survives reset.

## Timing
- Read latency is fixed at 1. `avs_readdata` is valid on the cycle after `avs_read` is sampled and holds until the next read.
- A write updates its register on the clock edge that samples `avs_write`. A read issued the following cycle returns the new value.
- Key to DATA latency: 2 synchroniser cycles, plus `DEBOUNCE_CYCLES` stable cycles, plus 1 for the stable register.
- EDGECAP and PRESSCNT update on the same edge as the stable value changes.
- `irq` is registered: `irq <= |(EDGECAP & IRQMASK)`. It rises 1 cycle after the EDGECAP bit sets and falls 1 cycle after the W1C write or mask clear.

## Configuration
- With `KEY_PIO_IRQ_EN` defined: IRQMASK, EDGECAP and `irq` are implemented as described.
- Without `KEY_PIO_IRQ_EN`:
  - IRQMASK and EDGECAP are not built and read as 0.
  - Writes to addresses 1 and 2 are ignored.
  - `irq` is tied to 0.
  - DATA and PRESSCNT are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=16`, `WIDTH=4`, `KEY_PIO_IRQ_EN` defined.
- Reset, then read all four addresses → 0, 0, 0, 0; `irq` = 0 throughout.
- Drive `key_n=4'b1110` steady → DATA reads 0x1 no earlier than cycle 2+16+1; EDGECAP = 0x1; PRESSCNT = 1; `irq` stays 0 with mask 0.
- Pulse `key_n[1]` low for 10 cycles → DATA, EDGECAP and PRESSCNT unchanged.
- Write IRQMASK = 0x1, then press key 0 → `irq` = 1 one cycle after EDGECAP[0] sets. Write 0x1 to EDGECAP → `irq` = 0 the next cycle.
- Press keys 2 and 3 so both stable values rise on the same cycle → PRESSCNT += 2 and EDGECAP = 0xC. Issue a W1C of 0x4 in the same cycle key 2's edge lands → EDGECAP[2] remains 1.
- Preload PRESSCNT to 0xFFFF via presses, then one more press → 0x0000. Assert reset mid-debounce → all registers 0 and no press is counted after release.
